// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM controller: FSM state encoding
// and the width of the strobe wait counter.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    // Holds 0..7, the full WAIT_CYCLES range.
    localparam int WAIT_W = 3;

endpackage

// File: rtl/sram_ctrl_arb.sv
// Two-way round-robin arbiter for the SRAM controller.
// Ports: a_req/b_req requests, last_b = B was granted last,
// gnt one-hot grant ({B, A}), zero when nobody requests.
module sram_ctrl_arb (
    input  logic       a_req,
    input  logic       b_req,
    input  logic       last_b,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (a_req && !b_req): gnt = 2'b01;
            (!a_req && b_req): gnt = 2'b10;
            (a_req && b_req):  gnt = last_b ? 2'b01 : 2'b10;
            default:           gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// Two-requester asynchronous SRAM controller: SETUP/STROBE/RECOVER
// access sequence with round-robin arbitration between A and B.
// Ports: CLK/RST (sync, active-high); A_*/B_* request side with
// one-cycle ACK pulses; shared RDATA; SRAM_* pins with active-low
// write strobe and output enable, all registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH       = 12,
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_REQ,
    input  logic             A_WR,
    input  logic [DEPTH-1:0] A_ADDR,
    input  logic [WIDTH-1:0] A_WDATA,
    output logic             A_ACK,
    input  logic             B_REQ,
    input  logic             B_WR,
    input  logic [DEPTH-1:0] B_ADDR,
    input  logic [WIDTH-1:0] B_WDATA,
    output logic             B_ACK,
    output logic [WIDTH-1:0] RDATA,
    output logic [DEPTH-1:0] SRAM_ADDR,
    output logic             SRAM_N_WE,
    output logic             SRAM_N_OE,
    output logic [WIDTH-1:0] SRAM_WDATA,
    input  logic [WIDTH-1:0] SRAM_RDATA
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DEPTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]        own_q, own_d;
    logic              last_b_q, last_b_d;
    logic              n_we_q, n_we_d;
    logic              n_oe_q, n_oe_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [1:0]        gnt;

    sram_ctrl_arb u_arb (
        .a_req  (A_REQ),
        .b_req  (B_REQ),
        .last_b (last_b_q),
        .gnt    (gnt)
    );

    // Outputs are registered: the *_d values describe the pins
    // for the state being entered, so the SRAM sees clean strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        own_d    = own_q;
        last_b_d = last_b_q;
        n_we_d   = 1'b1;
        n_oe_d   = 1'b1;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    own_d    = gnt;
                    last_b_d = gnt[1];
                    wr_d     = gnt[1] ? B_WR    : A_WR;
                    addr_d   = gnt[1] ? B_ADDR  : A_ADDR;
                    wdata_d  = gnt[1] ? B_WDATA : A_WDATA;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                n_we_d  = !wr_q;
                n_oe_d  = wr_q;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == WAIT_LAST) begin
                    a_ack_d = own_q[0];
                    b_ack_d = own_q[1];
                    if (!wr_q) begin
                        rdata_d = SRAM_RDATA;
                    end
                    state_d = RECOVER;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    n_we_d = !wr_q;
                    n_oe_d = wr_q;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            own_q    <= 2'b00;
            last_b_q <= 1'b1;
            n_we_q   <= 1'b1;
            n_oe_q   <= 1'b1;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            own_q    <= own_d;
            last_b_q <= last_b_d;
            n_we_q   <= n_we_d;
            n_oe_q   <= n_oe_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
        end
    end

    assign A_ACK      = a_ack_q;
    assign B_ACK      = b_ack_q;
    assign RDATA      = rdata_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_WDATA = wdata_q;
    assign SRAM_N_WE  = n_we_q;
    assign SRAM_N_OE  = n_oe_q;

`ifdef FORMAL
    logic strobe_n;
    assign strobe_n = SRAM_N_WE & SRAM_N_OE;

    a_no_overlap: assert property (
        @(posedge CLK) !(!SRAM_N_WE && !SRAM_N_OE));

    a_ack_onehot0: assert property (
        @(posedge CLK) !(A_ACK && B_ACK));

    a_strobe_len: assert property (
        @(posedge CLK) disable iff (RST)
        $fell(strobe_n) |-> (!strobe_n) [*WAIT_CYCLES+1] ##1 strobe_n);
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: table of single accesses on a
// WAIT_CYCLES=0 instance plus hand sequences for arbitration,
// reset abort and a WAIT_CYCLES=3 instance.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_wr, b_req, b_wr;
    logic [11:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [7:0]  rdata;
    logic [11:0] s_addr;
    logic        s_n_we, s_n_oe;
    logic [7:0]  s_wdata, s_rdata;
    logic [7:0]  mem [4096];

    logic        c_req, c_wr;
    logic [11:0] c_addr;
    logic [7:0]  c_wdata;
    logic        c_ack, c_b_ack;
    logic [7:0]  c_rdata;
    logic [11:0] c_s_addr;
    logic        c_n_we, c_n_oe;
    logic [7:0]  c_s_wdata, c_s_rdata;
    logic [7:0]  mem3 [4096];
    logic        z1;
    logic [11:0] z12;
    logic [7:0]  z8;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    logic [7:0] last_rd;

    sram_ctrl #(.DEPTH(12), .WIDTH(8), .WAIT_CYCLES(0)) u0 (
        .CLK(clk), .RST(rst),
        .A_REQ(a_req), .A_WR(a_wr), .A_ADDR(a_addr),
        .A_WDATA(a_wdata), .A_ACK(a_ack),
        .B_REQ(b_req), .B_WR(b_wr), .B_ADDR(b_addr),
        .B_WDATA(b_wdata), .B_ACK(b_ack),
        .RDATA(rdata), .SRAM_ADDR(s_addr),
        .SRAM_N_WE(s_n_we), .SRAM_N_OE(s_n_oe),
        .SRAM_WDATA(s_wdata), .SRAM_RDATA(s_rdata)
    );

    sram_ctrl #(.DEPTH(12), .WIDTH(8), .WAIT_CYCLES(3)) u3 (
        .CLK(clk), .RST(rst),
        .A_REQ(c_req), .A_WR(c_wr), .A_ADDR(c_addr),
        .A_WDATA(c_wdata), .A_ACK(c_ack),
        .B_REQ(z1), .B_WR(z1), .B_ADDR(z12),
        .B_WDATA(z8), .B_ACK(c_b_ack),
        .RDATA(c_rdata), .SRAM_ADDR(c_s_addr),
        .SRAM_N_WE(c_n_we), .SRAM_N_OE(c_n_oe),
        .SRAM_WDATA(c_s_wdata), .SRAM_RDATA(c_s_rdata)
    );

    // SRAM models: write on falling edge of N_WE, async read.
    always @(negedge s_n_we) mem[s_addr] = s_wdata;
    always @(negedge c_n_we) mem3[c_s_addr] = c_s_wdata;
    assign s_rdata   = s_n_oe ? 8'h00 : mem[s_addr];
    assign c_s_rdata = c_n_oe ? 8'h00 : mem3[c_s_addr];

    always @(negedge clk) begin
        if (!s_n_we && !s_n_oe) overlap++;
        if (!c_n_we && !c_n_oe) overlap++;
        if (a_ack && b_ack) overlap++;
        if (c_b_ack) overlap++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 8'h00;
    endtask

    typedef struct {
        bit          is_b;
        bit          wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
        bit          mangle;
    } txn_t;

    txn_t tbl[8];

    task automatic run_txn(input txn_t t, input int idx);
        int lat = -1, we_first = -1, we_cnt = 0, oe_cnt = 0;
        bit other = 0, addr_bad = 0, wd_bad = 0;
        logic [7:0] got = 8'h00;
        string p;
        p = $sformatf("t%0d", idx);
        @(posedge clk); #1;
        if (t.is_b) begin
            b_req = 1; b_wr = t.wr; b_addr = t.addr; b_wdata = t.wdata;
        end else begin
            a_req = 1; a_wr = t.wr; a_addr = t.addr; a_wdata = t.wdata;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1 && t.mangle) begin
                if (t.is_b) begin b_addr = 12'hFFF; b_wdata = 8'hFF; end
                else begin a_addr = 12'hFFF; a_wdata = 8'hFF; end
            end
            if (!s_n_we) begin
                we_cnt++;
                if (we_first < 0) we_first = k;
            end
            if (!s_n_oe) oe_cnt++;
            if (k >= 1 && k <= 3) begin
                if (s_addr !== t.addr) addr_bad = 1;
                if (t.wr && s_wdata !== t.wdata) wd_bad = 1;
            end
            if (t.is_b ? a_ack : b_ack) other = 1;
            if ((t.is_b ? b_ack : a_ack) && lat < 0) begin
                lat = k;
                got = rdata;
                if (t.is_b) b_req = 0; else a_req = 0;
            end
        end
        chk({p, "_lat"}, lat, 3);
        chk({p, "_we_cnt"}, we_cnt, t.wr ? 1 : 0);
        chk({p, "_oe_cnt"}, oe_cnt, t.wr ? 0 : 1);
        chk({p, "_addr_stable"}, addr_bad, 0);
        chk({p, "_wdata_stable"}, wd_bad, 0);
        chk({p, "_other_ack"}, other, 0);
        if (t.wr) begin
            chk({p, "_we_cycle"}, we_first, 2);
            chk({p, "_mem"}, mem[t.addr], t.wdata);
            chk({p, "_rdata_hold"}, got, last_rd);
        end else begin
            chk({p, "_rdata"}, got, t.exp);
            last_rd = t.exp;
        end
    endtask

    task automatic run3(input bit wr, input logic [11:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp);
        int lat = -1, first = -1, we_cnt = 0, oe_cnt = 0;
        logic [7:0] got = 8'h00;
        @(posedge clk); #1;
        c_req = 1; c_wr = wr; c_addr = addr; c_wdata = wd;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!c_n_we) we_cnt++;
            if (!c_n_oe) oe_cnt++;
            if ((!c_n_we || !c_n_oe) && first < 0) first = k;
            if (c_ack && lat < 0) begin
                lat = k;
                got = c_rdata;
                c_req = 0;
            end
        end
        chk("w3_lat", lat, 6);
        chk("w3_first_strobe", first, 2);
        chk("w3_we_cnt", we_cnt, wr ? 4 : 0);
        chk("w3_oe_cnt", oe_cnt, wr ? 0 : 4);
        if (wr) chk("w3_mem", mem3[addr], wd);
        else chk("w3_rdata", got, exp);
    endtask

    initial begin
        int who[4];
        int at[4];
        logic [7:0] rd[4];
        int n;
        bit seen;

        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem3[0] = 8'h4E;
        z1 = 0; z12 = '0; z8 = '0;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;

        tbl[0] = '{0, 1, 12'h3A5, 8'h5C, 8'h00, 0};
        tbl[1] = '{1, 0, 12'h3A5, 8'h00, 8'h5C, 0};
        tbl[2] = '{1, 1, 12'h000, 8'hC3, 8'h00, 0};
        tbl[3] = '{0, 0, 12'h000, 8'h00, 8'hC3, 0};
        tbl[4] = '{0, 1, 12'hFFF, 8'hFF, 8'h00, 0};
        tbl[5] = '{1, 0, 12'hFFF, 8'h00, 8'hFF, 0};
        tbl[6] = '{0, 1, 12'h2B4, 8'h6D, 8'h00, 1};
        tbl[7] = '{1, 0, 12'h2B4, 8'h00, 8'h6D, 0};

        // Reset values, sampled while RST is still high.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_n_we", s_n_we, 1);
        chk("rst_n_oe", s_n_oe, 1);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_w3_strobes", {c_n_we, c_n_oe}, 2'b11);
        rst = 1'b0;
        last_rd = 8'h00;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], i);

        // Both requesters held: A,B,A,B every 4 cycles.
        do_reset();
        @(posedge clk); #1;
        a_req = 1; a_wr = 0; a_addr = 12'h3A5;
        b_req = 1; b_wr = 0; b_addr = 12'h000;
        n = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if ((a_ack || b_ack) && n < 4) begin
                who[n] = b_ack ? 1 : 0;
                at[n] = k;
                rd[n] = rdata;
            end
            if (a_ack || b_ack) n++;
        end
        a_req = 0; b_req = 0;
        chk("rr_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                chk($sformatf("rr%0d_who", i), who[i], i % 2);
                chk($sformatf("rr%0d_cycle", i), at[i], 3 + 4 * i);
                chk($sformatf("rr%0d_rdata", i), rd[i],
                    (i % 2) ? 8'hC3 : 8'h5C);
            end
        end

        // Reset during STROBE of an A write.
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        a_req = 1; a_wr = 1; a_addr = 12'h123; a_wdata = 8'h77;
        repeat (3) @(negedge clk);
        chk("abort_in_strobe", s_n_we, 0);
        rst = 1; a_req = 0;
        @(negedge clk);
        chk("abort_n_we", s_n_we, 1);
        chk("abort_n_oe", s_n_oe, 1);
        chk("abort_acks", {a_ack, b_ack}, 0);
        rst = 0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack || b_ack || !s_n_we || !s_n_oe) seen = 1;
        end
        chk("abort_idle", seen, 0);
        @(posedge clk); #1;
        a_req = 1; a_wr = 0; a_addr = 12'h3A5;
        b_req = 1; b_wr = 0; b_addr = 12'h000;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((a_ack || b_ack) && n == 0) begin
                who[0] = b_ack ? 1 : 0;
                at[0] = k;
            end
            if (a_ack || b_ack) n++;
            if (a_ack) a_req = 0;
            if (b_ack) b_req = 0;
        end
        a_req = 0; b_req = 0;
        chk("abort_prio_who", who[0], 0);
        chk("abort_prio_cycle", at[0], 3);
        chk("abort_prio_count", n, 2);

        // WAIT_CYCLES=3 instance.
        run3(0, 12'h000, 8'h00, 8'h4E);
        run3(1, 12'h005, 8'h99, 8'h00);

        chk("no_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
